sram_ot_acc: RTL and testbench

Parametrised output-tile SRAM for the CONV datapath. It is the successor to the fixed 3136x26 output buffer and holds one output feature map (56x56 by default). Beyond plain writes, it accumulates partial sums across input channels in place, using a read-modify-write with saturation. On final_flag it autonomously drains the whole map through a valid/ready stream, applying optional ReLU and clearing each word as it is read.

---
 rtl/sram_ot_acc_if.sv | 31 +++
 rtl/sram_ot_acc.sv | 137 +++++++++++++
 tb/tb_sram_ot_acc.sv | 243 ++++++++++++++++++++++++
 3 files changed

// File: rtl/sram_ot_acc_if.sv
// Host write/read/accumulate port and drain stream of the output-tile SRAM.
interface sram_ot_acc_if #(
    parameter int AW    = 12,
    parameter int WIDTH = 26
);
    logic                    wr_en;
    logic                    acc_mode;
    logic [AW-1:0]           addr;
    logic signed [WIDTH-1:0] din;
    logic                    rd_en;
    logic signed [WIDTH-1:0] dout;
    logic                    dout_valid;
    logic                    final_flag;
    logic                    drain_valid;
    logic                    drain_ready;
    logic [AW-1:0]           drain_addr;
    logic signed [WIDTH-1:0] drain_data;
    logic                    drain_done;
    logic                    busy;
    logic                    overflow;

    modport master (
        output wr_en, acc_mode, addr, din, rd_en, final_flag, drain_ready,
        input  dout, dout_valid, drain_valid, drain_addr, drain_data, drain_done, busy, overflow
    );

    modport slave (
        input  wr_en, acc_mode, addr, din, rd_en, final_flag, drain_ready,
        output dout, dout_valid, drain_valid, drain_addr, drain_data, drain_done, busy, overflow
    );
endinterface

// File: rtl/sram_ot_acc.sv
// Output-tile SRAM: overwrite, saturating in-place accumulate, host read and
// a self-clearing drain stream started by final_flag.
module sram_ot_acc #(
    parameter int DEPTH   = 3136,
    parameter int WIDTH   = 26,
    parameter bit RELU_EN = 1'b1
) (
    input  logic         clk,
    input  logic         rst_n,
    sram_ot_acc_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0]             DEPTH_W   = (AW+1)'(DEPTH);
    localparam logic [AW-1:0]           LAST_ADDR = AW'(DEPTH - 1);
    localparam logic signed [WIDTH-1:0] MAX_V     = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic signed [WIDTH-1:0] MIN_V     = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DRAIN} state_t;

    function automatic logic signed [WIDTH-1:0] sat(input logic [WIDTH:0] s);
        if (s[WIDTH] != s[WIDTH-1]) return s[WIDTH] ? MIN_V : MAX_V;
        return s[WIDTH-1:0];
    endfunction

    function automatic logic clamped(input logic [WIDTH:0] s);
        return s[WIDTH] ^ s[WIDTH-1];
    endfunction

    function automatic logic signed [WIDTH-1:0] relu(input logic signed [WIDTH-1:0] v);
        return (RELU_EN && v[WIDTH-1]) ? '0 : v;
    endfunction

    logic signed [WIDTH-1:0] r_mem [DEPTH];

    state_t                  r_state, w_state_nxt;
    logic                    r_vld_p1, r_vld_p2;
    logic [AW-1:0]           r_addr_p1, r_addr_p2;
    logic signed [WIDTH-1:0] r_din_p1, r_sum_p2;
    logic signed [WIDTH-1:0] r_dout, r_drain_data;
    logic                    r_dout_valid, r_drain_valid, r_drain_done, r_overflow;
    logic [AW-1:0]           r_drain_addr;

    logic                    w_idle, w_in_range, w_ovw, w_acc, w_rd, w_drain_hs;
    logic signed [WIDTH-1:0] w_old_p1, w_sat_p1, w_rd_val;
    logic [WIDTH:0]          w_sum_p1;
    logic [AW-1:0]           w_drain_rd_addr, w_rd_addr;

    assign w_idle     = (r_state == S_IDLE);
    assign w_in_range = ({1'b0, bus.addr} < DEPTH_W);
    assign w_ovw      = w_idle && bus.wr_en && w_in_range && !bus.acc_mode;
    assign w_acc      = w_idle && bus.wr_en && w_in_range && bus.acc_mode;
    assign w_rd       = w_idle && bus.rd_en && !bus.wr_en;
    assign w_drain_hs = (r_state == S_DRAIN) && r_drain_valid && bus.drain_ready;

    // Stage 1 -> 2: read old value (forwarding the pending stage-2 sum) and saturate
    assign w_old_p1 = (r_vld_p2 && r_addr_p2 == r_addr_p1) ? r_sum_p2 : r_mem[r_addr_p1];
    assign w_sum_p1 = {w_old_p1[WIDTH-1], w_old_p1} + {r_din_p1[WIDTH-1], r_din_p1};
    assign w_sat_p1 = sat(w_sum_p1);

    // Shared read port sees both in-flight accumulates, newest first
    assign w_drain_rd_addr = r_drain_valid ? r_drain_addr + AW'(1) : r_drain_addr;
    assign w_rd_addr       = (r_state == S_DRAIN) ? w_drain_rd_addr : bus.addr;
    assign w_rd_val = (r_vld_p1 && r_addr_p1 == w_rd_addr) ? w_sat_p1 :
                      (r_vld_p2 && r_addr_p2 == w_rd_addr) ? r_sum_p2 : r_mem[w_rd_addr];

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (bus.final_flag) w_state_nxt = S_WAIT;
            S_WAIT:  w_state_nxt = S_DRAIN;
            S_DRAIN: if (w_drain_hs && r_drain_addr == LAST_ADDR) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= S_IDLE;
            r_vld_p1      <= 1'b0;
            r_vld_p2      <= 1'b0;
            r_dout        <= '0;
            r_dout_valid  <= 1'b0;
            r_drain_valid <= 1'b0;
            r_drain_addr  <= '0;
            r_drain_data  <= '0;
            r_drain_done  <= 1'b0;
            r_overflow    <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_vld_p1 <= w_acc;
            // A later overwrite of the same word supersedes the in-flight accumulate
            r_vld_p2 <= r_vld_p1 && !(w_ovw && bus.addr == r_addr_p1);

            r_dout_valid <= w_rd;
            if (w_rd) r_dout <= w_in_range ? w_rd_val : '0;

            if (w_idle && bus.final_flag) r_overflow <= 1'b0;
            if (r_vld_p1 && clamped(w_sum_p1)) r_overflow <= 1'b1;

            r_drain_done <= 1'b0;
            if (r_state == S_DRAIN) begin
                if (!r_drain_valid) begin
                    r_drain_valid <= 1'b1;
                    r_drain_data  <= relu(w_rd_val);
                end else if (bus.drain_ready) begin
                    if (r_drain_addr == LAST_ADDR) begin
                        r_drain_valid <= 1'b0;
                        r_drain_addr  <= '0;
                        r_drain_done  <= 1'b1;
                    end else begin
                        r_drain_addr <= r_drain_addr + AW'(1);
                        r_drain_data <= relu(w_rd_val);
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        r_addr_p1 <= bus.addr;
        r_din_p1  <= bus.din;
        r_addr_p2 <= r_addr_p1;
        r_sum_p2  <= w_sat_p1;
        if (r_vld_p2)   r_mem[r_addr_p2]    <= r_sum_p2;
        if (w_ovw)      r_mem[bus.addr]     <= bus.din;
        if (w_drain_hs) r_mem[r_drain_addr] <= '0;
    end

    assign bus.dout        = r_dout;
    assign bus.dout_valid  = r_dout_valid;
    assign bus.drain_valid = r_drain_valid;
    assign bus.drain_addr  = r_drain_addr;
    assign bus.drain_data  = r_drain_data;
    assign bus.drain_done  = r_drain_done;
    assign bus.busy        = (r_state != S_IDLE);
    assign bus.overflow    = r_overflow;
endmodule

// File: tb/tb_sram_ot_acc.sv
// Directed bench for sram_ot_acc: a ReLU instance plus a raw-output twin
// driven by the same stimulus.
module tb_sram_ot_acc;
    localparam int DEPTH = 3136;
    localparam int WIDTH = 26;
    localparam int AW    = 12;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    sram_ot_acc_if #(.AW(AW), .WIDTH(WIDTH)) bus ();
    sram_ot_acc_if #(.AW(AW), .WIDTH(WIDTH)) bus_raw ();

    sram_ot_acc #(.DEPTH(DEPTH), .WIDTH(WIDTH), .RELU_EN(1'b1)) u_dut (
        .clk(clk), .rst_n(rst_n), .bus(bus));
    sram_ot_acc #(.DEPTH(DEPTH), .WIDTH(WIDTH), .RELU_EN(1'b0)) u_dut_raw (
        .clk(clk), .rst_n(rst_n), .bus(bus_raw));

    assign bus_raw.wr_en       = bus.wr_en;
    assign bus_raw.acc_mode    = bus.acc_mode;
    assign bus_raw.addr        = bus.addr;
    assign bus_raw.din         = bus.din;
    assign bus_raw.rd_en       = bus.rd_en;
    assign bus_raw.final_flag  = bus.final_flag;
    assign bus_raw.drain_ready = bus.drain_ready;

    int n_chk = 0;
    int n_err = 0;
    int mon_words, mon_done, mon_bad, mon_dv;
    logic signed [WIDTH-1:0] cap [DEPTH];
    logic signed [WIDTH-1:0] cap_raw0;

    task automatic check_val(input string tag, input logic signed [63:0] got,
                             input logic signed [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_wr(input int a, input int d, input logic acc);
        bus.wr_en    = 1'b1;
        bus.acc_mode = acc;
        bus.addr     = a[AW-1:0];
        bus.din      = d[WIDTH-1:0];
        tick();
        bus.wr_en    = 1'b0;
        bus.acc_mode = 1'b0;
    endtask

    task automatic do_rd(input int a);
        bus.rd_en = 1'b1;
        bus.addr  = a[AW-1:0];
        tick();
        bus.rd_en = 1'b0;
    endtask

    task automatic clear_host();
        bus.wr_en      = 1'b0;
        bus.acc_mode   = 1'b0;
        bus.rd_en      = 1'b0;
        bus.final_flag = 1'b0;
    endtask

    // Observes the drain stream; optionally injects host traffic and a second final_flag
    task automatic drain_monitor(input int cycles, input int inject_at, input int stop_words);
        int a;
        mon_words = 0; mon_done = 0; mon_bad = 0; mon_dv = 0;
        for (int c = 0; c < cycles; c++) begin
            if (mon_words >= stop_words) break;
            if (c == inject_at) begin
                bus.wr_en = 1'b1; bus.acc_mode = 1'b0; bus.rd_en = 1'b1;
                bus.addr = 12'd3000; bus.din = 26'sd55; bus.final_flag = 1'b1;
            end else begin
                clear_host();
            end
            if (bus.drain_valid && bus.drain_ready) begin
                a = int'(bus.drain_addr);
                if (a != mon_words) mon_bad++;
                cap[a] = bus.drain_data;
                if (a == 0) cap_raw0 = bus_raw.drain_data;
                mon_words++;
            end
            if (bus.drain_done) mon_done++;
            if (bus.dout_valid) mon_dv++;
            tick();
        end
        clear_host();
    endtask

    initial begin
        int nz;
        clear_host();
        bus.addr = '0;
        bus.din = '0;
        bus.drain_ready = 1'b0;
        tick(); tick();
        check_val("rst_dout", bus.dout, 0);
        check_val("rst_dout_valid", bus.dout_valid, 0);
        check_val("rst_drain_valid", bus.drain_valid, 0);
        check_val("rst_drain_addr", bus.drain_addr, 0);
        check_val("rst_drain_data", bus.drain_data, 0);
        check_val("rst_drain_done", bus.drain_done, 0);
        check_val("rst_busy", bus.busy, 0);
        check_val("rst_overflow", bus.overflow, 0);
        rst_n = 1'b1;
        tick();

        for (int a = 0; a < DEPTH; a++) do_wr(a, 0, 1'b0);

        do_wr(5, 123, 1'b0);
        do_rd(3136);
        check_val("rd_oor_data", bus.dout, 0);
        check_val("rd_oor_valid", bus.dout_valid, 1);
        do_rd(5);
        check_val("rd5_data", bus.dout, 123);
        check_val("rd5_valid", bus.dout_valid, 1);
        tick();
        check_val("idle_valid", bus.dout_valid, 0);
        check_val("dout_hold", bus.dout, 123);

        bus.wr_en = 1'b1; bus.rd_en = 1'b1; bus.addr = 12'd6; bus.din = 26'sd77;
        tick();
        clear_host();
        check_val("wr_rd_valid", bus.dout_valid, 0);
        do_rd(6);
        check_val("wr_rd_write", bus.dout, 77);

        do_wr(7, 0, 1'b0);
        for (int i = 0; i < 10; i++) do_wr(7, 3, 1'b1);
        do_rd(7);
        check_val("acc_b2b", bus.dout, 30);
        do_wr(8, 0, 1'b0);
        for (int i = 0; i < 4; i++) do_wr((i % 2 == 0) ? 7 : 8, 1, 1'b1);
        do_rd(7);
        check_val("acc_il_7", bus.dout, 32);
        do_rd(8);
        check_val("acc_il_8", bus.dout, 2);
        check_val("ovf_clear", bus.overflow, 0);

        do_wr(9, 33554430, 1'b0);
        do_wr(9, 5, 1'b1);
        do_rd(9);
        check_val("sat_pos", bus.dout, 33554431);
        check_val("ovf_pos", bus.overflow, 1);
        do_wr(10, -33554431, 1'b0);
        do_wr(10, -5, 1'b1);
        do_rd(10);
        check_val("sat_neg", bus.dout, -33554432);
        check_val("ovf_neg", bus.overflow, 1);
        do_wr(4000, 9, 1'b0);

        for (int a = 5; a <= 10; a++) do_wr(a, 0, 1'b0);
        do_wr(0, -4, 1'b0);
        do_wr(1, 9, 1'b0);
        bus.drain_ready = 1'b0;
        bus.final_flag = 1'b1;
        tick();
        bus.final_flag = 1'b0;
        check_val("wait_busy", bus.busy, 1);
        check_val("ovf_final", bus.overflow, 0);
        tick(); tick();
        for (int i = 0; i < 3; i++) begin
            check_val("bp_valid", bus.drain_valid, 1);
            check_val("bp_addr", bus.drain_addr, 0);
            check_val("bp_data_relu", bus.drain_data, 0);
            check_val("bp_data_raw", bus_raw.drain_data, -4);
            tick();
        end
        bus.drain_ready = 1'b1;
        drain_monitor(DEPTH + 5, -1, DEPTH + 1);
        check_val("dr1_words", mon_words, DEPTH);
        check_val("dr1_order", mon_bad, 0);
        check_val("dr1_done", mon_done, 1);
        check_val("dr1_busy", bus.busy, 0);
        check_val("dr1_w0", cap[0], 0);
        check_val("dr1_w1", cap[1], 9);
        check_val("dr1_raw0", cap_raw0, -4);
        nz = 0;
        for (int a = 2; a < DEPTH; a++) if (cap[a] != 0) nz++;
        check_val("dr1_rest_zero", nz, 0);
        do_rd(1);
        check_val("rd1_cleared", bus.dout, 0);
        do_rd(0);
        check_val("rd0_cleared", bus.dout, 0);

        bus.final_flag = 1'b1;
        tick();
        clear_host();
        bus.wr_en = 1'b1; bus.addr = 12'd2; bus.din = 26'sd55;
        tick();
        clear_host();
        drain_monitor(DEPTH + 10, 5, DEPTH + 1);
        check_val("dr2_words", mon_words, DEPTH);
        check_val("dr2_done", mon_done, 1);
        check_val("dr2_w2", cap[2], 0);
        check_val("dr2_w3000", cap[3000], 0);
        check_val("dr2_no_rd", mon_dv, 0);
        check_val("dr2_busy", bus.busy, 0);

        for (int a = 0; a <= 100; a++) do_wr(a, a + 1, 1'b0);
        bus.final_flag = 1'b1;
        tick();
        clear_host();
        drain_monitor(200, -1, 100);
        check_val("rst_mid_words", mon_words, 100);
        #2 rst_n = 1'b0;
        #1;
        check_val("rmid_valid", bus.drain_valid, 0);
        check_val("rmid_addr", bus.drain_addr, 0);
        check_val("rmid_data", bus.drain_data, 0);
        check_val("rmid_busy", bus.busy, 0);
        check_val("rmid_done", bus.drain_done, 0);
        check_val("rmid_dout_valid", bus.dout_valid, 0);
        #3 rst_n = 1'b1;
        tick();
        nz = 0;
        for (int a = 0; a < 100; a++) begin
            do_rd(a);
            if (bus.dout != 0 || bus.dout_valid != 1'b1) nz++;
        end
        check_val("rmid_cleared", nz, 0);
        do_rd(100);
        check_val("rmid_w100", bus.dout, 101);
        check_val("rmid_idle", bus.busy, 0);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog got timeout expected finish");
        $fatal(1, "watchdog");
    end
endmodule
